// File: rtl/cnt_bcd_down.sv
// cnt_bcd_down: multi-digit BCD countdown timer with start/stop control.
// Digits load in parallel (saturated to 9), decrement with a borrow ripple
// from digit 0 upward on each honoured tick, and `done` pulses for one cycle
// when the count reaches zero.
// Optional feature: define CNT_BCD_DOWN_AUTORELOAD_EN to make the terminal
// count reload from the last loaded value and keep running (periodic timer).
module cnt_bcd_down #(
  parameter int DIGITS = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  busy,
  output logic                  paused,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] CNT_ZERO = '0;
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           busy_q, busy_d;
  logic           paused_q, paused_d;
  logic           done_q, done_d;

  logic [W-1:0]   load_sat;
  logic [W-1:0]   cnt_dec;
  logic [DIGITS:0] borrow;

  assign borrow[0] = 1'b1;

  // Per-digit saturation of the preset and one-step BCD decrement.
  // A digit borrows only when every digit below it is zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] ld_digit;
    logic [3:0] cur_digit;
    assign ld_digit  = load_val[4*gi +: 4];
    assign cur_digit = cnt_q[4*gi +: 4];
    assign load_sat[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
    assign cnt_dec[4*gi +: 4]  = !borrow[gi]          ? cur_digit :
                                 (cur_digit == 4'd0)  ? 4'd9      :
                                                        cur_digit - 4'd1;
    assign borrow[gi+1] = borrow[gi] && (cur_digit == 4'd0);
  end

  // Next-state, count and pulse logic; load overrides everything but reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      cnt_d    = load_sat;
      reload_d = load_sat;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Starting from zero would never reach a terminal count; ignore it.
          if (start && (cnt_q != CNT_ZERO)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (en) begin
            if (cnt_q == CNT_ONE) begin
              done_d = 1'b1;
`ifdef CNT_BCD_DOWN_AUTORELOAD_EN
              if (reload_q != CNT_ZERO) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
              end
`else
              cnt_d   = CNT_ZERO;
              state_d = ST_IDLE;
`endif
            end else begin
              cnt_d = cnt_dec;
            end
          end
        end
        ST_PAUSE: begin
          // stop outranks start, so both together keep the block paused.
          if (!stop && start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d   = (state_d != ST_IDLE);
    paused_d = (state_d == ST_PAUSE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign cnt    = cnt_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cnt_bcd_down.sv
// Directed testbench for cnt_bcd_down (DIGITS=2 main instance plus a
// DIGITS=3 instance for the multi-digit borrow ripple).
module tb_cnt_bcd_down;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load, start, stop;
  logic [7:0]  load_val;
  logic [7:0]  cnt;
  logic        busy, paused, done;

  logic        en3, load3, start3, stop3;
  logic [11:0] load_val3;
  logic [11:0] cnt3;
  logic        busy3, paused3, done3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cnt_bcd_down #(.DIGITS(2)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .load(load),
    .load_val(load_val), .start(start), .stop(stop),
    .cnt(cnt), .busy(busy), .paused(paused), .done(done)
  );

  cnt_bcd_down #(.DIGITS(3)) u_dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en3), .load(load3),
    .load_val(load_val3), .start(start3), .stop(stop3),
    .cnt(cnt3), .busy(busy3), .paused(paused3), .done(done3)
  );

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int k);
    return 8'((k / 10) * 16 + (k % 10));
  endfunction

  initial begin
    logic [7:0] exp_cnt;
    logic       exp_done, exp_busy;

    rst_n = 1'b0; en = 0; load = 0; start = 0; stop = 0; load_val = '0;
    en3 = 0; load3 = 0; start3 = 0; stop3 = 0; load_val3 = '0;
    step();
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_paused", 32'(paused), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // Load 23 and count all the way down.
    load = 1; load_val = 8'h23; step(); load = 0;
    chk("load23_cnt", 32'(cnt), 32'h23);
    chk("load23_busy", 32'(busy), 32'h0);
    start = 1; step(); start = 0;
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_cnt", 32'(cnt), 32'h23);
    en = 1;
    for (int k = 22; k >= 0; k--) begin
      step();
      exp_cnt  = bcd2(k);
      exp_busy = (k != 0);
`ifdef CNT_BCD_DOWN_AUTORELOAD_EN
      if (k == 0) begin exp_cnt = 8'h23; exp_busy = 1'b1; end
`endif
      chk($sformatf("down_cnt_%0d", k), 32'(cnt), 32'(exp_cnt));
      chk($sformatf("down_done_%0d", k), 32'(done), 32'(k == 0));
      chk($sformatf("down_busy_%0d", k), 32'(busy), 32'(exp_busy));
    end
    en = 0; step();
    chk("done_deassert", 32'(done), 32'h0);

    // Three-digit borrow ripple 100 -> 099.
    load3 = 1; load_val3 = 12'h100; step(); load3 = 0;
    start3 = 1; step(); start3 = 0;
    en3 = 1; step(); en3 = 0;
    chk("ripple_cnt3", 32'(cnt3), 32'h099);
    chk("ripple_done3", 32'(done3), 32'h0);

    // Pause/resume priority at 05.
    load = 1; load_val = 8'h05; step(); load = 0;
    start = 1; step(); start = 0;
    stop = 1; en = 1; step(); stop = 0;
    chk("stop_en_cnt", 32'(cnt), 32'h05);
    chk("stop_paused", 32'(paused), 32'h1);
    chk("stop_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("paused_en_%0d", i), 32'(cnt), 32'h05);
    end
    start = 1; stop = 1; step(); stop = 0;
    chk("start_stop_paused", 32'(paused), 32'h1);
    step(); start = 0;
    chk("resume_cnt", 32'(cnt), 32'h05);
    chk("resume_paused", 32'(paused), 32'h0);
    step(); en = 0;
    chk("first_tick_cnt", 32'(cnt), 32'h04);

    // Load saturation and zero-start.
    load = 1; load_val = 8'hA7; step();
    chk("sat_cnt", 32'(cnt), 32'h97);
    load_val = 8'hFB; step();
    chk("sat_both_cnt", 32'(cnt), 32'h99);
    load_val = 8'h00; step(); load = 0;
    start = 1; step(); start = 0;
    chk("zero_start_busy", 32'(busy), 32'h0);
    chk("zero_start_done", 32'(done), 32'h0);
    en = 1; step(); en = 0;
    chk("zero_start_done2", 32'(done), 32'h0);
    chk("zero_start_cnt", 32'(cnt), 32'h00);

    // Load while running aborts to IDLE without done.
    load = 1; load_val = 8'h40; step(); load = 0;
    start = 1; step(); start = 0;
    en = 1; load = 1; load_val = 8'h37; step(); load = 0;
    chk("load_run_cnt", 32'(cnt), 32'h37);
    chk("load_run_busy", 32'(busy), 32'h0);
    chk("load_run_done", 32'(done), 32'h0);
    step(); en = 0;
    chk("load_run_idle_en", 32'(cnt), 32'h37);

    // Reset in the middle of a run.
    load = 1; load_val = 8'h12; step(); load = 0;
    start = 1; step(); start = 0;
    chk("pre_rst_busy", 32'(busy), 32'h1);
    en = 1; rst_n = 0; step(); rst_n = 1; en = 0;
    chk("midrst_cnt", 32'(cnt), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_paused", 32'(paused), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);

    // Short count from 02: reload behaviour depends on the build.
    load = 1; load_val = 8'h02; step(); load = 0;
    start = 1; step(); start = 0;
    en = 1;
    for (int t = 1; t <= 6; t++) begin
      step();
`ifdef CNT_BCD_DOWN_AUTORELOAD_EN
      exp_cnt  = (t % 2 == 1) ? 8'h01 : 8'h02;
      exp_done = (t % 2 == 0);
      exp_busy = 1'b1;
`else
      exp_cnt  = (t == 1) ? 8'h01 : 8'h00;
      exp_done = (t == 2);
      exp_busy = (t == 1);
`endif
      chk($sformatf("tc_cnt_%0d", t), 32'(cnt), 32'(exp_cnt));
      chk($sformatf("tc_done_%0d", t), 32'(done), 32'(exp_done));
      chk($sformatf("tc_busy_%0d", t), 32'(busy), 32'(exp_busy));
    end
    en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnt_bcd_down.md
# cnt_bcd_down

Multi-digit BCD countdown timer with start/stop control and a terminal-count pulse. It is the down-counting counterpart of the team's BCD up-counter. It consumes the same one-cycle enable tick (for example the 1 Hz strobe) and drives digit displays and alarm logic in the timer and stopwatch designs. Digits are loaded in parallel, decrement with borrow ripple from digit 0 upward, and the block signals `done` when the count reaches zero.

## Interface
- `DIGITS`, default 2: number of BCD digits; legal range 1–8.
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `sys_rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  count tick, one `sys_clk` cycle wide; honoured only in RUN.
- `load`  in  1  parallel load strobe.
- `load_val`  in  4*DIGITS  BCD preset; digit i occupies bits [4i+3:4i].
- `start`  in  1  start request, or resume request when paused.
- `stop`  in  1  pause request.
- `cnt`  out  4*DIGITS  current BCD count, registered.
- `busy`  out  1  high in RUN and PAUSE.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  one-cycle pulse when the count reaches zero.

## Operation
- States: IDLE, RUN, PAUSE. The encoding is internal.
- Reset (sys_rst_n=0 at an edge):
  - state goes to IDLE;
  - `cnt`=0, reload register=0;
  - `busy`=0, `paused`=0, `done`=0.
- Input priority per edge: reset > load > stop > start > en.
- `load` (any state):
  - `cnt` and the reload register take `load_val`;
  - any digit >9 is saturated to 9 per digit;
  - state goes to IDLE; `done`=0;
  - an `en` in the same cycle is ignored.
- IDLE:
  - `start` with `cnt`≠0 → RUN.
  - `start` with `cnt`=0 is ignored. No `done` is produced.
  - `stop` and `en` are ignored.
- RUN:
  - `stop` → PAUSE; `cnt` is held. This applies even if `en` is high in the same cycle.
  - `start` is ignored.
  - On `en`, the count decrements by one in BCD:
    - digit 0 decrements;
    - a digit at 0 becomes 9 and borrows from the next digit;
    - all digits update in the same edge.
- PAUSE:
  - `start` → RUN.
  - `en` is ignored. `stop` is ignored.
  - `start` and `stop` together → stays in PAUSE, because stop wins.
- Terminal count: when `en` is honoured in RUN with `cnt`=1 (all upper digits 0):
  - `cnt` becomes 0;
  - `done`=1 for exactly the next cycle;
  - further behaviour is set by Configuration.
- Arithmetic: `cnt` never holds a non-BCD digit and never underflows past zero.

## Timing
- `start`/`stop` take effect at the next edge. `busy`/`paused` are registered and reflect the new state one cycle after the request.
- An `en` sampled in the same cycle as `start` (from IDLE or PAUSE) is not counted. The first counted tick is the first `en` sampled while the state is RUN.
- Decrement latency: `en` high at edge k → `cnt` updated and visible after edge k.
- `done` is asserted in the same cycle that `cnt`=0 (or the reloaded value) first appears, then deasserts at the next edge.
- A reset during RUN or PAUSE aborts the count immediately. No `done` is produced.
- `load` during RUN aborts the count, leaves the block in IDLE, and produces no `done`.

## Configuration
- Macro: `CNT_BCD_DOWN_AUTORELOAD_EN`.
- Defined: at terminal count, `cnt` takes the reload register instead of 0, `done` pulses, and the state stays RUN (periodic timer). If the reload register is 0, the block goes to IDLE with `cnt`=0.
- Undefined: at terminal count, `cnt`=0 and the state goes to IDLE. The reload register is retained so that a new `load` is the only way to re-arm.

## Test plan
- Reset then load: DIGITS=2, load `load_val`=8'h23, start, apply 23 `en` ticks → `cnt` goes 23,22,…,20,19,…,01,00. `done` is a single pulse with `cnt`=8'h00; `busy` falls at the same edge.
- Borrow ripple: DIGITS=3, load 12'h100, start, one `en` → `cnt`=12'h099 in one edge.
- Pause/resume and priority:
  - `stop` together with `en` at `cnt`=8'h05 → `cnt` stays 05 and `paused`=1;
  - 3 `en` ticks while paused → no change;
  - `start` with `en` in the same cycle → still 05;
  - next `en` → 04.
- Load edge cases:
  - `load_val`=8'hA7 → `cnt`=8'h97;
  - `start` with `cnt`=8'h00 → stays IDLE with no `done`;
  - `load` during RUN at 8'h40 → IDLE, `cnt`=load value, no `done`.
- Reset mid-run: `sys_rst_n`=0 for one edge at `cnt`=8'h12 in RUN → `cnt`=0, IDLE, all outputs 0, no `done`.
- Macro defined: load 8'h02, start, 6 `en` ticks → `cnt` goes 01,00→02 (reload),01,02… with `done` pulsing every second tick and `busy` staying 1.
